// File: rtl/maze_collision_if.sv
// Player <-> collision responder <-> maze ROM signal bundle.
// master: the player/ROM side; slave: the collision scanner.
interface maze_collision_if;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  mapa_x;
  logic [2:0]  mapa_y;
  logic [14:0] tile_addr;
  logic        tile_rd;
  logic        tile_data;
  logic        collision;
  logic        scan_done;

  modport master (
    output x_pos, y_pos, mapa_x, mapa_y, tile_data,
    input  tile_addr, tile_rd, collision, scan_done
  );

  modport slave (
    input  x_pos, y_pos, mapa_x, mapa_y, tile_data,
    output tile_addr, tile_rd, collision, scan_done
  );
endinterface

// File: rtl/maze_collision.sv
// Maze collision scanner: snapshots the player position, reads the wall bit
// under each of the four sprite corners from the synchronous maze ROM and
// publishes the OR of the in-range hits once per 6-cycle scan.
module maze_collision #(
  parameter int H_START    = 144,
  parameter int V_START    = 35,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SPRITE     = 16,
  parameter int TILE_SHIFT = 5
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  maze_collision_if.slave bus
);
  localparam logic [2:0] SNAP = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] RD3  = 3'd4;
  localparam logic [2:0] LAST = 3'd5;

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);
  localparam logic [10:0] OFS  = 11'(SPRITE - 1);

  logic [2:0]  state, state_nxt;
  logic [9:0]  snap_x, snap_y;
  logic [2:0]  snap_mx, snap_my;
  logic        acc;
  logic [3:0]  valid;
  logic        coll_q;
  logic [14:0] addr_q;

  logic        rd_state;
  logic [1:0]  corner, prev_corner;
  logic [10:0] cx, cy, rx, ry;
  logic [4:0]  col;
  logic [3:0]  row;
  logic        in_range;
  logic [14:0] addr_now;

  // Free-running scan sequencer, no stall conditions.
  always_comb begin
    state_nxt = SNAP;
    case (state)
      SNAP:    state_nxt = RD0;
      RD0:     state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RD3;
      RD3:     state_nxt = LAST;
      LAST:    state_nxt = SNAP;
      default: state_nxt = SNAP;
    endcase
  end

  // Corner under test this cycle and its tile address; corner bit0 selects
  // the right edge, bit1 the bottom edge. 11-bit sums cannot wrap.
  always_comb begin
    rd_state    = (state >= RD0) && (state <= RD3);
    corner      = 2'(state - RD0);
    prev_corner = 2'(state - RD1);
    cx          = {1'b0, snap_x} + (corner[0] ? OFS : 11'd0);
    cy          = {1'b0, snap_y} + (corner[1] ? OFS : 11'd0);
    in_range    = rd_state && (cx >= H_LO) && (cx < H_HI) &&
                  (cy >= V_LO) && (cy < V_HI);
    rx          = cx - H_LO;
    ry          = cy - V_LO;
    col         = 5'(rx >> TILE_SHIFT);
    row         = 4'(ry >> TILE_SHIFT);
    addr_now    = {snap_my, snap_mx, row, col};
  end

  // Off-screen corners issue no read and leave the address bus parked.
  assign bus.tile_rd   = in_range;
  assign bus.tile_addr = in_range ? addr_now : addr_q;
  assign bus.collision = coll_q;
  assign bus.scan_done = (state == LAST);

  // Snapshot, per-corner valid flags, hit accumulator and result register.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state   <= SNAP;
      snap_x  <= '0;
      snap_y  <= '0;
      snap_mx <= '0;
      snap_my <= '0;
      acc     <= 1'b0;
      valid   <= '0;
      coll_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= bus.tile_addr;
      case (state)
        SNAP: begin
          snap_x  <= bus.x_pos;
          snap_y  <= bus.y_pos;
          snap_mx <= bus.mapa_x;
          snap_my <= bus.mapa_y;
          acc     <= 1'b0;
        end
        RD0, RD1, RD2, RD3: begin
          valid[corner] <= in_range;
          // ROM data now belongs to the corner issued last cycle.
          if (state != RD0)
            acc <= acc | (bus.tile_data & valid[prev_corner]);
        end
        LAST: coll_q <= acc | (bus.tile_data & valid[3]);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/maze_collision.md
Name: maze_collision

Overview:
- Responder side of the player movement interface: consumes the player's pixel position and room coordinates and produces the `collision` flag the player FSM reads.
- Continuously scans the four corners of the 16x16 player sprite against a 1-bit-per-tile wall map held in an external synchronous ROM (one ROM per maze, 8x8 rooms).
- Sits between the player block and the maze ROM, in the CLOCK_25 domain.

Parameters:
- H_START, 144, first active pixel column in VGA timing space (96+48).
- V_START, 35, first active line in VGA timing space (2+33).
- H_ACTIVE, 640, active width in pixels.
- V_ACTIVE, 480, active height in lines.
- SPRITE, 16, sprite edge in pixels; corner offset is SPRITE-1.
- TILE_SHIFT, 5, log2 of the tile edge (32 px tile, giving 20x15 tiles per room).

Ports:
- CLOCK_25  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-high reset.
- x_pos  input  10  player left edge, VGA timing coordinates.
- y_pos  input  10  player top edge, VGA timing coordinates.
- mapa_x  input  3  room column.
- mapa_y  input  3  room row.
- tile_addr  output  15  ROM address {mapa_y, mapa_x, row[3:0], col[4:0]}.
- tile_rd  output  1  ROM read strobe.
- tile_data  input  1  ROM data, 1 = wall; valid exactly one cycle after tile_rd.
- collision  output  1  registered result of the last completed scan.
- scan_done  output  1  one-cycle pulse when collision is updated.

Behaviour:
- Clock and reset: one clock, CLOCK_25. reset is asynchronous and active-high. While reset is high:
  - collision=0, scan_done=0, tile_rd=0, tile_addr=0.
  - FSM is forced to SNAP and the accumulator is cleared.
- FSM: SNAP -> RD0 -> RD1 -> RD2 -> RD3 -> LAST -> SNAP. It runs unconditionally, so one scan takes 6 cycles.
- SNAP:
  - Latch x_pos, y_pos, mapa_x, mapa_y into a snapshot register.
  - Clear the accumulator.
  - Inputs are ignored for the rest of the scan.
- Corner order: RD0=(x,y), RD1=(x+15,y), RD2=(x,y+15), RD3=(x+15,y+15). Sums are 11-bit, so there is no wrap.
- Corner range check: a corner is in-range iff H_START <= cx < H_START+H_ACTIVE and V_START <= cy < V_START+V_ACTIVE.
- Tile coordinates: rx=cx-H_START and ry=cy-V_START. col=rx>>TILE_SHIFT (0..19), row=ry>>TILE_SHIFT (0..14).
- RDk, in-range corner: drive tile_addr for corner k with tile_rd=1, and latch valid_k=1.
- RDk, out-of-range corner: tile_rd=0, tile_addr holds its previous value, and valid_k=0. Out-of-range corners are never walls, so room-edge wrap is free.
- Accumulate: in RD1..RD3 and in LAST, acc |= tile_data & valid_(k-1), using the corner issued in the previous cycle.
- LAST:
  - collision <= acc | (tile_data & valid_3).
  - scan_done=1 for this cycle only.
  - tile_rd=0.
- Latency: a change on the inputs is reflected on collision at most 12 cycles later. This is well below the 150000-cycle movement step, so the player sees a settled flag.
- Between scan_done pulses collision holds its value; there is no glitch mid-scan.
- Input change mid-scan: no effect until the next SNAP.
- tile_data is sampled only in RD1..RD3 and LAST; it is don't-care otherwise.
- Reset asserted mid-scan: the scan is aborted and collision=0. The first result after release appears 6 cycles after the first CLOCK_25 edge.

Test Plan:
- Reset pos: room (0,7), x=455, y=266, ROM all zeros.
  - Required: tile_rd high in RD0..RD3 with addresses 28905, 28906, 28905, 28906.
  - Required: collision=0 and scan_done every 6 cycles.
- Wall hit: same position, ROM[28906]=1.
  - Required: collision=1 at the first scan_done.
  - Then clear ROM[28906]: collision returns to 0 one scan later.
- Left off-screen: x=130, y=266, ROM all ones.
  - Required: RD0 and RD2 have tile_rd=0; RD1 and RD3 address col 0 (x+15=145 gives rx=1).
  - Required: collision=1.
  - With only col 0 cleared in the ROM: collision=0.
- Fully off-screen: x=120, y=20.
  - Required: tile_rd never asserted and collision=0, regardless of ROM contents.
- Mid-scan input change: x switched from 455 to 600 during RD2.
  - Required: the current scan still uses 455.
  - Required: the next scan's RD0 addresses col 14 (600-144=456, 456>>5=14).
- Mid-scan reset: assert reset in RD2 while collision=1.
  - Required: collision=0 immediately.
  - Required: after release, RD0 is issued on the second edge and scan_done arrives on the sixth.
